mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MAX_WAIT, default 16, SHALL set the number of cycles waited for grant or response before abort.
REQ-002 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 valid_i  in  1  instruction present from EX/MEM.
REQ-005 mem_read_i, mem_write_i  in  1 each  load / store request.
REQ-006 funct3_i  in  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 alu_result_i  in  32  byte address, or ALU result for non-memory ops.
REQ-008 store_data_i  in  32  rs2 value for stores.
REQ-009 rd_addr_i  in  5, reg_write_i  in  1, mem_to_reg_i  in  1  writeback control.
REQ-010 data_req_o, data_we_o  out  1 each, data_be_o  out  4, data_addr_o  out  32, data_wdata_o  out  32  memory request.
REQ-011 data_gnt_i, data_rvalid_i  in  1 each, data_rdata_i  in  32  memory grant/response.
REQ-012 read_data_o, alu_result_o  out  32, rd_addr_o  out  5, reg_write_o, mem_to_reg_o  out  1 each  to MEM/WB register.
REQ-013 stall_o  out  1  freeze upstream; access_err_o, timeout_o  out  1 each  error pulses.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_GNT, WAIT_RVALID, DONE.
REQ-015 Access = valid_i & (mem_read_i | mem_write_i); non-access cycles in IDLE: stall_o=0, outputs pass through, no request.
REQ-016 Access error: W with addr[1:0]!=0, H/HU with addr[0]!=0, store funct3 not 000/001/010, load funct3 011/110/111 -> no request, access_err_o=1 that cycle, reg_write_o=0, stall_o=0, stay IDLE.
REQ-017 Legal access in IDLE: data_req_o=1 combinationally same cycle; no grant -> WAIT_GNT; grant on load -> WAIT_RVALID; grant on store -> DONE.
REQ-018 WAIT_GNT: data_req_o held 1 with stable addr/we/be/wdata until data_gnt_i; then as REQ-017.
REQ-019 WAIT_RVALID: data_req_o=0; on data_rvalid_i capture formatted data into internal register, go DONE.
REQ-020 DONE: stall_o=0, read_data_o = captured register, next state IDLE.
REQ-021 stall_o=1 in IDLE with legal access and in WAIT_GNT, WAIT_RVALID; reg_write_o SHALL equal reg_write_i & ~stall_o (no duplicate writeback while MEM/WB keeps sampling).
REQ-022 data_addr_o = {alu_result_i[31:2],2'b00}; data_we_o = mem_write_i.
REQ-023 data_be_o: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; data_wdata_o: B {4{byte}}, H {2{half}}, W as is.
REQ-024 Load format: lane by addr[1:0]; 000/001 sign-extend, 100/101 zero-extend, 010 unchanged.
REQ-025 Wait counter SHALL clear on IDLE entry, increment each WAIT_GNT/WAIT_RVALID cycle; reaching MAX_WAIT -> timeout_o pulse 1 cycle, data_req_o=0, go DONE with reg_write_o=0 and read_data_o=0.
REQ-026 data_rvalid_i outside WAIT_RVALID and data_gnt_i outside request cycles SHALL be ignored.
REQ-027 Stalls 0 cycles for non-access; load with immediate gnt and rvalid next cycle: 2 stall cycles then DONE.

Reset
REQ-028 rst_i low SHALL immediately force IDLE, counter 0, captured data 0, data_req_o=0, timeout_o=0, stall_o=0 regardless of state; outstanding access abandoned.
REQ-029 Combinational pass-through outputs SHALL follow inputs during reset except data_req_o, reg_write_o, forced 0.

Verification
REQ-030 LB addr 0x103, rdata 0x80FF_FF01, gnt immediate, rvalid next cycle -> stall 2 cycles, DONE read_data_o=0xFFFF_FF80, reg_write_o=1.
REQ-031 SH addr 0x202, store_data 0x1234_ABCD -> be=1100, wdata=0xABCD_ABCD, addr=0x200, we=1, gnt delayed 3 cycles -> stall 4 cycles, no rvalid wait.
REQ-032 LW addr 0x101 -> no data_req_o, access_err_o=1 one cycle, reg_write_o=0, stall_o=0.
REQ-033 Load, gnt never asserted, MAX_WAIT=16 -> timeout_o pulse after 16 wait cycles, read_data_o=0, reg_write_o=0, FSM back to IDLE.
REQ-034 rst_i low during WAIT_RVALID -> data_req_o/stall_o 0 same cycle, IDLE; late rvalid after release ignored.
REQ-035 Back-to-back ADD then LHU addr 0x6 rdata 0xFACE_0000 -> ADD passes with no stall; LHU read_data_o=0x0000_FACE.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues load/store requests on a grant/response bus,
// formats load data and holds the upstream pipeline while an access is outstanding.
module mem_stage #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        reg_write_i,
   input  logic        mem_to_reg_i,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   output logic [31:0] read_data_o,
   output logic [31:0] alu_result_o,
   output logic [4:0]  rd_addr_o,
   output logic        reg_write_o,
   output logic        mem_to_reg_o,
   output logic        stall_o,
   output logic        access_err_o,
   output logic        timeout_o
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2,
      DONE        = 2'd3
   } state_t;

   state_t         state_r, state_next_s;
   logic [CW-1:0]  cnt_r;
   logic [31:0]    rdata_r;
   logic           timeout_r;

   logic           access_s, misalign_s, bad_code_s, legal_s, err_s;
   logic           timeout_hit_s;
   logic [1:0]     off_s;

   function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   byte_enable = 4'b0001 << off;
         2'b01:   byte_enable = 4'b0011 << off;
         2'b10:   byte_enable = 4'b1111;
         default: byte_enable = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   store_lanes = {4{d[7:0]}};
         2'b01:   store_lanes = {2{d[15:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
      logic [31:0] sh;
      sh = d >> {off, 3'b000};
      case (f3)
         3'b000:  load_format = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_format = {{16{sh[15]}}, sh[15:0]};
         3'b100:  load_format = {24'h000000, sh[7:0]};
         3'b101:  load_format = {16'h0000, sh[15:0]};
         default: load_format = d;
      endcase
   endfunction

   assign off_s         = alu_result_i[1:0];
   assign access_s      = valid_i & (mem_read_i | mem_write_i);
   assign data_addr_o   = {alu_result_i[31:2], 2'b00};
   assign data_we_o     = mem_write_i;
   assign data_be_o     = byte_enable(funct3_i, off_s);
   assign data_wdata_o  = store_lanes(funct3_i, store_data_i);
   assign alu_result_o  = alu_result_i;
   assign rd_addr_o     = rd_addr_i;
   assign mem_to_reg_o  = mem_to_reg_i;
   assign timeout_o     = timeout_r;

   // Access legality: alignment and funct3 codes valid for the access direction
   always_comb begin
      misalign_s = ((funct3_i[1:0] == 2'b10) && (off_s != 2'b00)) ||
                   ((funct3_i[1:0] == 2'b01) && off_s[0]);
      if (mem_write_i) begin
         bad_code_s = (funct3_i != 3'b000) && (funct3_i != 3'b001) && (funct3_i != 3'b010);
      end else begin
         bad_code_s = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
      end
      err_s   = (state_r == IDLE) && access_s && (misalign_s || bad_code_s);
      legal_s = access_s && !misalign_s && !bad_code_s;
   end

   // Abort when the last permitted wait cycle passes without progress
   always_comb begin
      if ((state_r == WAIT_GNT) && !data_gnt_i) begin
         timeout_hit_s = (cnt_r == CW'(MAX_WAIT - 1));
      end else if ((state_r == WAIT_RVALID) && !data_rvalid_i) begin
         timeout_hit_s = (cnt_r == CW'(MAX_WAIT - 1));
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // State, wait counter, captured load data and timeout pulse
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r   <= IDLE;
         cnt_r     <= '0;
         rdata_r   <= 32'h0000_0000;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         timeout_r <= timeout_hit_s;
         if ((state_r == WAIT_GNT) || (state_r == WAIT_RVALID)) begin
            cnt_r <= cnt_r + CW'(1);
         end else begin
            cnt_r <= '0;
         end
         if ((state_r == WAIT_RVALID) && data_rvalid_i) begin
            rdata_r <= load_format(funct3_i, off_s, data_rdata_i);
         end else if (timeout_hit_s) begin
            rdata_r <= 32'h0000_0000;
         end else begin
            rdata_r <= rdata_r;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (legal_s && data_gnt_i) begin
               state_next_s = mem_write_i ? DONE : WAIT_RVALID;
            end else if (legal_s) begin
               state_next_s = WAIT_GNT;
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT_GNT: begin
            if (data_gnt_i) begin
               state_next_s = mem_write_i ? DONE : WAIT_RVALID;
            end else if (timeout_hit_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = WAIT_GNT;
            end
         end
         WAIT_RVALID: begin
            if (data_rvalid_i || timeout_hit_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = WAIT_RVALID;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Request, stall and writeback outputs; reset forces the handshake quiet
   always_comb begin
      data_req_o   = 1'b0;
      stall_o      = 1'b0;
      read_data_o  = 32'h0000_0000;
      case (state_r)
         IDLE: begin
            data_req_o = legal_s;
            stall_o    = legal_s;
         end
         WAIT_GNT: begin
            data_req_o = 1'b1;
            stall_o    = 1'b1;
         end
         WAIT_RVALID: begin
            stall_o    = 1'b1;
         end
         DONE: begin
            read_data_o = rdata_r;
         end
         default: begin
            data_req_o = 1'b0;
         end
      endcase
      if (!rst_i) begin
         data_req_o = 1'b0;
         stall_o    = 1'b0;
      end else begin
         data_req_o = data_req_o;
      end
      access_err_o = err_s;
      reg_write_o  = rst_i & reg_write_i & ~stall_o & ~err_s & ~timeout_r;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: drives the bus handshake per scenario and compares
// formatted load results popped from an expectation queue when each access completes.
module tb_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i, mem_read_i, mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] alu_result_i, store_data_i;
   logic [4:0]  rd_addr_i;
   logic        reg_write_i, mem_to_reg_i;
   logic        data_req_o, data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic [31:0] read_data_o, alu_result_o;
   logic [4:0]  rd_addr_o;
   logic        reg_write_o, mem_to_reg_o, stall_o, access_err_o, timeout_o;

   typedef struct {
      logic [31:0] data;
      logic        wr;
   } exp_t;
   exp_t sb_q[$];

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk_i = ~clk_i;

   mem_stage #(.MAX_WAIT(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_read_i(mem_read_i),
      .mem_write_i(mem_write_i), .funct3_i(funct3_i), .alu_result_i(alu_result_i),
      .store_data_i(store_data_i), .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
      .mem_to_reg_i(mem_to_reg_i), .data_req_o(data_req_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
      .read_data_o(read_data_o), .alu_result_o(alu_result_o), .rd_addr_o(rd_addr_o),
      .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .stall_o(stall_o),
      .access_err_o(access_err_o), .timeout_o(timeout_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
      alu_result_i = 32'h0; store_data_i = 32'h0; rd_addr_i = 5'd0;
      reg_write_i = 1'b0; mem_to_reg_i = 1'b0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic rw);
      valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
      alu_result_i = addr; store_data_i = wdata; rd_addr_i = 5'd7;
      reg_write_i = rw; mem_to_reg_i = rd;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      set_idle();
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1);
      @(negedge clk_i);
      total_cnt++; if (data_req_o !== 1'b0) $display("FAIL reset_req got %b want 0", data_req_o); else pass_cnt++;
      total_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %b want 0", stall_o); else pass_cnt++;
      total_cnt++; if (reg_write_o !== 1'b0) $display("FAIL reset_regwrite got %b want 0", reg_write_o); else pass_cnt++;
      total_cnt++; if (timeout_o !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout_o); else pass_cnt++;
      total_cnt++; if (alu_result_o !== 32'h0000_0040) $display("FAIL reset_passthru got %h want 00000040", alu_result_o); else pass_cnt++;
      total_cnt++; if (read_data_o !== 32'h0) $display("FAIL reset_rdata got %h want 0", read_data_o); else pass_cnt++;
      step();
      set_idle();
      step();
      rst_i = 1'b1;
      step();
   endtask

   task automatic test_lb();
      int stalls = 0;
      exp_t e;
      drive(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1);
      data_gnt_i = 1'b1;
      sb_q.push_back('{data: 32'hFFFF_FF80, wr: 1'b1});
      @(negedge clk_i);
      total_cnt++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h0000_0100 || data_be_o !== 4'b1000 || data_we_o !== 1'b0)
         $display("FAIL lb_request got req=%b addr=%h be=%b we=%b want 1 00000100 1000 0", data_req_o, data_addr_o, data_be_o, data_we_o);
      else pass_cnt++;
      total_cnt++; if (reg_write_o !== 1'b0) $display("FAIL lb_regwrite_stalled got %b want 0", reg_write_o); else pass_cnt++;
      if (stall_o) stalls++;
      step();
      data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h80FF_FF01;
      @(negedge clk_i);
      total_cnt++; if (data_req_o !== 1'b0) $display("FAIL lb_req_in_rvalid got %b want 0", data_req_o); else pass_cnt++;
      if (stall_o) stalls++;
      step();
      data_rvalid_i = 1'b0;
      @(negedge clk_i);
      if (stall_o) stalls++;
      total_cnt++; if (stalls !== 2) $display("FAIL lb_stall_cycles got %0d want 2", stalls); else pass_cnt++;
      if (sb_q.size() == 0) begin
         total_cnt++; $display("FAIL lb_scoreboard got empty want entry");
      end else begin
         e = sb_q.pop_front();
         total_cnt++; if (read_data_o !== e.data || reg_write_o !== e.wr)
            $display("FAIL lb_result got %h/%b want %h/%b", read_data_o, reg_write_o, e.data, e.wr);
         else pass_cnt++;
      end
      step();
      set_idle();
   endtask

   task automatic test_sh();
      int stalls = 0;
      drive(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 1'b0);
      @(negedge clk_i);
      total_cnt++; if (data_req_o !== 1'b1 || data_be_o !== 4'b1100 || data_wdata_o !== 32'hABCD_ABCD || data_addr_o !== 32'h0000_0200 || data_we_o !== 1'b1)
         $display("FAIL sh_request got req=%b be=%b wdata=%h addr=%h we=%b want 1 1100 abcdabcd 00000200 1", data_req_o, data_be_o, data_wdata_o, data_addr_o, data_we_o);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk_i);
         if (!stall_o) break;
         stalls++;
         total_cnt++; if (data_req_o !== 1'b1 || data_be_o !== 4'b1100) $display("FAIL sh_req_hold cycle %0d got %b/%b want 1/1100", i, data_req_o, data_be_o); else pass_cnt++;
         step();
         data_gnt_i = (i == 2);
      end
      total_cnt++; if (stalls !== 4) $display("FAIL sh_stall_cycles got %0d want 4", stalls); else pass_cnt++;
      total_cnt++; if (data_req_o !== 1'b0) $display("FAIL sh_done_req got %b want 0", data_req_o); else pass_cnt++;
      step();
      set_idle();
   endtask

   task automatic test_access_err();
      logic [2:0]  f3;
      logic [31:0] addr;
      logic        wr;
      for (int i = 0; i < 5; i++) begin
         case (i)
            0: begin f3 = 3'b010; addr = 32'h0000_0101; wr = 1'b0; end
            1: begin f3 = 3'b001; addr = 32'h0000_0003; wr = 1'b0; end
            2: begin f3 = 3'b101; addr = 32'h0000_0000; wr = 1'b1; end
            3: begin f3 = 3'b011; addr = 32'h0000_0000; wr = 1'b0; end
            default: begin f3 = 3'b010; addr = 32'h0000_0002; wr = 1'b1; end
         endcase
         drive(~wr, wr, f3, addr, 32'h0, 1'b1);
         @(negedge clk_i);
         total_cnt++; if (access_err_o !== 1'b1 || data_req_o !== 1'b0 || reg_write_o !== 1'b0 || stall_o !== 1'b0)
            $display("FAIL access_err case %0d got err=%b req=%b rw=%b stall=%b want 1 0 0 0", i, access_err_o, data_req_o, reg_write_o, stall_o);
         else pass_cnt++;
         step();
         set_idle();
         @(negedge clk_i);
         total_cnt++; if (access_err_o !== 1'b0 || stall_o !== 1'b0) $display("FAIL access_err_pulse case %0d got %b/%b want 0/0", i, access_err_o, stall_o); else pass_cnt++;
         step();
      end
   endtask

   task automatic test_load_formats();
      logic [2:0]  f3;
      logic [31:0] addr, rdata;
      exp_t        e;
      logic        done;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin f3 = 3'b000; addr = 32'h0000_0011; rdata = 32'h0000_7F00; e = '{data: 32'h0000_007F, wr: 1'b1}; end
            1: begin f3 = 3'b100; addr = 32'h0000_0022; rdata = 32'h00AB_0000; e = '{data: 32'h0000_00AB, wr: 1'b1}; end
            2: begin f3 = 3'b001; addr = 32'h0000_0030; rdata = 32'h1234_8001; e = '{data: 32'hFFFF_8001, wr: 1'b1}; end
            default: begin f3 = 3'b010; addr = 32'h0000_0044; rdata = 32'hCAFE_BABE; e = '{data: 32'hCAFE_BABE, wr: 1'b1}; end
         endcase
         drive(1'b1, 1'b0, f3, addr, 32'h0, 1'b1);
         data_gnt_i = 1'b1;
         sb_q.push_back(e);
         step();
         data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = rdata;
         done = 1'b0;
         for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk_i);
            if (!stall_o) done = 1'b1;
            else begin step(); data_rvalid_i = 1'b0; end
         end
         if (!done || sb_q.size() == 0) begin
            total_cnt++; $display("FAIL load_fmt case %0d got no completion want DONE", i);
         end else begin
            e = sb_q.pop_front();
            total_cnt++; if (read_data_o !== e.data || reg_write_o !== e.wr)
               $display("FAIL load_fmt case %0d got %h/%b want %h/%b", i, read_data_o, reg_write_o, e.data, e.wr);
            else pass_cnt++;
         end
         step();
         set_idle();
      end
   endtask

   task automatic test_timeout();
      int   tcyc = -1;
      exp_t e;
      drive(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1);
      sb_q.push_back('{data: 32'h0, wr: 1'b0});
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (timeout_o) begin tcyc = i; break; end
         step();
      end
      total_cnt++; if (tcyc !== 17) $display("FAIL timeout_cycle got %0d want 17", tcyc); else pass_cnt++;
      if (sb_q.size() == 0) begin
         total_cnt++; $display("FAIL timeout_scoreboard got empty want entry");
      end else begin
         e = sb_q.pop_front();
         total_cnt++; if (read_data_o !== e.data || reg_write_o !== e.wr || data_req_o !== 1'b0)
            $display("FAIL timeout_result got %h/%b req=%b want %h/%b req=0", read_data_o, reg_write_o, data_req_o, e.data, e.wr);
         else pass_cnt++;
      end
      step();
      set_idle();
      @(negedge clk_i);
      total_cnt++; if (timeout_o !== 1'b0 || stall_o !== 1'b0) $display("FAIL timeout_pulse got %b/%b want 0/0", timeout_o, stall_o); else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0, 1'b1);
      data_gnt_i = 1'b1;
      step();
      data_gnt_i = 1'b0;
      @(negedge clk_i);
      total_cnt++; if (stall_o !== 1'b1) $display("FAIL rstmid_in_wait got %b want 1", stall_o); else pass_cnt++;
      #1 rst_i = 1'b0;
      #1;
      total_cnt++; if (stall_o !== 1'b0 || data_req_o !== 1'b0) $display("FAIL rstmid_same_cycle got %b/%b want 0/0", stall_o, data_req_o); else pass_cnt++;
      step();
      set_idle();
      step();
      rst_i = 1'b1;
      step();
      data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      total_cnt++; if (stall_o !== 1'b0 || data_req_o !== 1'b0) $display("FAIL rstmid_late_rvalid got %b/%b want 0/0", stall_o, data_req_o); else pass_cnt++;
      step();
      data_rvalid_i = 1'b0;
      @(negedge clk_i);
      total_cnt++; if (read_data_o !== 32'h0 || stall_o !== 1'b0) $display("FAIL rstmid_idle got %h/%b want 0/0", read_data_o, stall_o); else pass_cnt++;
      step();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      drive(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1);
      rd_addr_i = 5'd5;
      @(negedge clk_i);
      total_cnt++; if (stall_o !== 1'b0 || data_req_o !== 1'b0 || reg_write_o !== 1'b1 || alu_result_o !== 32'h55 || rd_addr_o !== 5'd5)
         $display("FAIL b2b_add got stall=%b req=%b rw=%b alu=%h rd=%0d want 0 0 1 00000055 5", stall_o, data_req_o, reg_write_o, alu_result_o, rd_addr_o);
      else pass_cnt++;
      step();
      drive(1'b1, 1'b0, 3'b101, 32'h0000_0006, 32'h0, 1'b1);
      data_gnt_i = 1'b1;
      sb_q.push_back('{data: 32'h0000_FACE, wr: 1'b1});
      @(negedge clk_i);
      total_cnt++; if (data_req_o !== 1'b1 || data_be_o !== 4'b1100) $display("FAIL b2b_lhu_req got %b/%b want 1/1100", data_req_o, data_be_o); else pass_cnt++;
      step();
      data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hFACE_0000;
      step();
      data_rvalid_i = 1'b0;
      @(negedge clk_i);
      if (sb_q.size() == 0 || stall_o !== 1'b0) begin
         total_cnt++; $display("FAIL b2b_lhu got stall=%b queue=%0d want DONE", stall_o, sb_q.size());
      end else begin
         e = sb_q.pop_front();
         total_cnt++; if (read_data_o !== e.data || reg_write_o !== e.wr)
            $display("FAIL b2b_lhu_result got %h/%b want %h/%b", read_data_o, reg_write_o, e.data, e.wr);
         else pass_cnt++;
      end
      step();
      set_idle();
   endtask

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_access_err();
      test_load_formats();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      total_cnt++; if (sb_q.size() != 0) $display("FAIL scoreboard_drain got %0d want 0", sb_q.size()); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
